board_renderer: RTL and testbench

- Reads the stored board out of ram_board, the reader side of the writes made by add_to_ram, and repaints it to the VGA framebuffer one cell at a time.
- The main control FSM uses it after a piece lands or lines clear, and at start-up. It takes one module_select bit and reports back on one module_complete bit.
- It shares the VGA X/Y/colour/writeEn path with draw_tetromino. Control muxes the two.

---
 rtl/board_renderer.sv | 184 ++++++++++++++++++
 tb/tb_board_renderer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : board_renderer                                               |
// | Description : Reads the stored board from ram_board and repaints it to     |
// |               the VGA framebuffer one CELL_PX x CELL_PX cell at a time.    |
// |               Optional macro BOARD_GRID_EN paints the right and bottom     |
// |               pixel row/column of each cell in GRID_COLOUR.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module board_renderer #(
  parameter int         BOARD_W     = 10,
  parameter int         BOARD_H     = 20,
  parameter int         CELL_PX     = 4,
  parameter int         X_ORIGIN    = 60,
  parameter int         Y_ORIGIN    = 20,
  parameter int         RAM_LATENCY = 1,
  parameter logic [5:0] BG_COLOUR   = 6'h00
`ifdef BOARD_GRID_EN
  , parameter logic [5:0] GRID_COLOUR = 6'h15
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] row_first,
  input  logic [4:0] row_last,
  output logic [7:0] ram_addr,
  input  logic [5:0] ram_q,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [5:0] colour,
  output logic       writeEn,
  output logic       complete
);

  localparam int COL_W  = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam int PX_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int WAIT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT_RD = 3'd2,
    PAINT   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        hi_q, hi_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [PX_W-1:0]   py_q, py_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]        cell_q, cell_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [5:0]        colour_q, colour_d;

  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [5:0] pix_colour;
  logic       px_last, py_last, col_last, painting;

  always_comb begin
    pix_x    = 8'(X_ORIGIN + int'(col_q) * CELL_PX + int'(px_q));
    pix_y    = 7'(Y_ORIGIN + int'(row_q) * CELL_PX + int'(py_q));
    px_last  = (int'(px_q) == CELL_PX - 1);
    py_last  = (int'(py_q) == CELL_PX - 1);
    col_last = (int'(col_q) == BOARD_W - 1);
`ifdef BOARD_GRID_EN
    pix_colour = (px_last || py_last) ? GRID_COLOUR : cell_q;
`else
    pix_colour = cell_q;
`endif
  end

  assign painting = (state_q == PAINT);
  assign ram_addr = 8'(int'(row_q) * BOARD_W + int'(col_q));
  assign writeEn  = painting;
  assign complete = (state_q == DONE);
  // Pixel outputs follow the live pixel while painting, otherwise the last one plotted.
  assign X        = painting ? pix_x      : x_q;
  assign Y        = painting ? pix_y      : y_q;
  assign colour   = painting ? pix_colour : colour_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    hi_d     = hi_q;
    col_d    = col_q;
    px_d     = px_q;
    py_d     = py_q;
    wait_d   = wait_q;
    cell_d   = cell_q;
    x_d      = painting ? pix_x      : x_q;
    y_d      = painting ? pix_y      : y_q;
    colour_d = painting ? pix_colour : colour_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          row_d   = row_first;
          hi_d    = (int'(row_last) > BOARD_H - 1) ? 5'(BOARD_H - 1) : row_last;
          col_d   = '0;
          state_d = (row_first > hi_d) ? DONE : ADDR;
        end
      end
      ADDR: begin
        wait_d  = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (int'(wait_q) == RAM_LATENCY - 1) begin
          cell_d  = (ram_q == 6'd0) ? BG_COLOUR : ram_q;
          px_d    = '0;
          py_d    = '0;
          state_d = PAINT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      PAINT: begin
        if (px_last) begin
          px_d = '0;
          if (py_last) begin
            py_d = '0;
            if (!col_last) begin
              col_d   = col_q + 1'b1;
              state_d = ADDR;
            end else if (row_q < hi_q) begin
              col_d   = '0;
              row_d   = row_q + 1'b1;
              state_d = ADDR;
            end else begin
              state_d = DONE;
            end
          end else begin
            py_d = py_q + 1'b1;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Dropping enable mid-render aborts without a completion pulse.
    if (state_q != IDLE && !enable) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      hi_q     <= '0;
      col_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      wait_q   <= '0;
      cell_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      hi_q     <= hi_d;
      col_q    <= col_d;
      px_q     <= px_d;
      py_q     <= py_d;
      wait_q   <= wait_d;
      cell_q   <= cell_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_board_renderer                                            |
// | Description : Self-checking bench for board_renderer (latency 1 and 3).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_board_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en1, en3;
  logic [4:0] row_first, row_last;

  logic [7:0] addr1, addr3, x1, x3;
  logic [6:0] y1, y3;
  logic [5:0] c1, c3, q1, q3, p3a, p3b;
  logic       we1, we3, cp1, cp3;

  logic [5:0] mem [0:255];

  int vectors    = 0;
  int miscompares = 0;
  int sel        = 1;

  board_renderer #(.RAM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .enable(en1), .row_first(row_first), .row_last(row_last),
    .ram_addr(addr1), .ram_q(q1), .X(x1), .Y(y1), .colour(c1), .writeEn(we1), .complete(cp1)
  );

  board_renderer #(.RAM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .enable(en3), .row_first(row_first), .row_last(row_last),
    .ram_addr(addr3), .ram_q(q3), .X(x3), .Y(y3), .colour(c3), .writeEn(we3), .complete(cp3)
  );

  // RAM models: one register stage per cycle of read latency.
  always @(posedge clk) q1 <= mem[addr1];
  always @(posedge clk) begin
    p3a <= mem[addr3];
    p3b <= p3a;
    q3  <= p3b;
  end

  logic [7:0] s_addr, s_x;
  logic [6:0] s_y;
  logic [5:0] s_c;
  logic       s_we, s_cp;
  assign s_addr = (sel == 3) ? addr3 : addr1;
  assign s_x    = (sel == 3) ? x3 : x1;
  assign s_y    = (sel == 3) ? y3 : y1;
  assign s_c    = (sel == 3) ? c3 : c1;
  assign s_we   = (sel == 3) ? we3 : we1;
  assign s_cp   = (sel == 3) ? cp3 : cp1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_colour(input logic [5:0] v, input int px, input int py);
    logic [5:0] c;
    c = (v == 6'd0) ? 6'h00 : v;
`ifdef BOARD_GRID_EN
    if (px == 3 || py == 3) c = 6'h15;
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ram(input int mode);
    for (int i = 0; i < 256; i++) begin
      if (mode == 0) mem[i] = 6'h00;
      else mem[i] = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
    end
  endtask

  // Runs one render on the selected DUT and checks every plotted pixel,
  // the write count and the completion cycle against the expected sequence.
  task automatic do_render(input int lo, input int hi_in, input int lat);
    logic [31:0] exp_q[$];
    int hi, n, cyc, wr, ccyc, limit;
    bit done;
    hi = (hi_in > 19) ? 19 : hi_in;
    exp_q.delete();
    for (int r = lo; r <= hi; r++)
      for (int c = 0; c < 10; c++)
        for (int py = 0; py < 4; py++)
          for (int px = 0; px < 4; px++)
            exp_q.push_back({3'b0, 8'(r * 10 + c), 8'(60 + c * 4 + px), 7'(20 + r * 4 + py),
                             exp_colour(mem[r * 10 + c], px, py)});
    n     = (lo <= hi) ? (hi - lo + 1) * 10 : 0;
    limit = n * (1 + lat + 16) + 1;
    sel       = lat;
    row_first = 5'(lo);
    row_last  = 5'(hi_in);
    if (lat == 3) en3 = 1'b1; else en1 = 1'b1;
    cyc = 0; wr = 0; ccyc = -1; done = 1'b0;
    while (!done && cyc < limit + 20) begin
      tick();
      cyc++;
      if (cyc == 1 && n > 0) check("first_addr", 32'(s_addr), 32'(lo * 10));
      if (s_we) begin
        if (wr < exp_q.size())
          check("pixel", {3'b0, s_addr, s_x, s_y, s_c}, exp_q[wr]);
        wr++;
      end
      if (s_cp) begin
        ccyc = cyc;
        done = 1'b1;
      end
    end
    en1 = 1'b0;
    en3 = 1'b0;
    check("write_count", 32'(wr), 32'(exp_q.size()));
    check("complete_cycle", 32'(ccyc), 32'(limit));
    tick();
    check("complete_pulse_width", 32'(s_cp), 32'd0);
  endtask

  initial begin
    int lo, hi, bad;
    reset = 1'b1; en1 = 1'b0; en3 = 1'b0; row_first = '0; row_last = '0;
    fill_ram(0);
    repeat (3) tick();
    check("reset_outputs_l1", {3'b0, addr1, x1, y1, c1}, 32'd0);
    check("reset_strobes_l1", {30'b0, we1, cp1}, 32'd0);
    check("reset_outputs_l3", {3'b0, addr3, x3, y3, c3}, 32'd0);
    reset = 1'b0;
    tick();

    // Full empty board
    do_render(0, 19, 1);

    // Single coloured cell at row 1, column 3
    mem[13] = 6'h30;
    do_render(1, 1, 1);

    // Clamped and empty ranges
    fill_ram(1);
    do_render(18, 25, 1);
    do_render(5, 4, 1);

    // Random contents and ranges
    for (int k = 0; k < 4; k++) begin
      fill_ram(1);
      lo = $urandom_range(0, 19);
      hi = $urandom_range(lo, 25);
      do_render(lo, hi, 1);
    end

    // Abort after 50 cycles, then restart
    sel = 1; row_first = 5'd0; row_last = 5'd19; en1 = 1'b1;
    repeat (50) tick();
    en1 = 1'b0;
    tick();
    check("abort_writeEn", 32'(we1), 32'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (we1 || cp1) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    do_render(3, 3, 1);

    // Three-cycle RAM latency
    fill_ram(1);
    do_render(0, 1, 3);
    lo = $urandom_range(0, 19);
    do_render(lo, lo + 2, 3);

    // Reset in the middle of painting
    sel = 1; row_first = 5'd2; row_last = 5'd2; en1 = 1'b1;
    bad = 0;
    while (!we1 && bad < 20) begin
      tick();
      bad++;
    end
    check("reached_paint", 32'(we1), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("midpaint_reset_outputs", {3'b0, addr1, x1, y1, c1}, 32'd0);
    check("midpaint_reset_strobes", {30'b0, we1, cp1}, 32'd0);
    reset = 1'b0;
    en1 = 1'b0;
    repeat (2) tick();
    check("idle_after_reset", {30'b0, we1, cp1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
